// File: rtl/boid_plotter.sv
// boid_plotter
//   Frame-rate rasteriser for a double-buffered 1-bit boid framebuffer. Each
//   accepted frame tick pulses fb_swap, then walks the boid position RAM and
//   writes a SPRITE_SIZE x SPRITE_SIZE block of set pixels per boid, one pixel
//   slot per clock. Off-screen pixels are clipped, but their slots are still
//   spent so frame timing does not depend on boid positions.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   frame_start       one-cycle frame tick (ignored and counted while busy)
//   boid_addr         read index into the boid position RAM (registered)
//   boid_x, boid_y    RAM read data, valid one cycle after boid_addr
//   fb_swap           one-cycle buffer-swap pulse to the framebuffer
//   fb_we             framebuffer write enable (write data is always 1)
//   fb_write_addr     framebuffer write address, y*SCREEN_W + x
//   busy              high while a frame is being drawn
//   frame_done        one-cycle pulse alongside the final write slot
//   dropped_frames    saturating count of ignored frame_start pulses
module boid_plotter #(
    parameter int NUM_BOIDS      = 64,
    parameter int BOID_IDX_WIDTH = 6,
    parameter int COORD_WIDTH    = 10,
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int ADDR_WIDTH     = 19,
    parameter int SPRITE_SIZE    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      frame_start,
    output logic [BOID_IDX_WIDTH-1:0] boid_addr,
    input  logic [COORD_WIDTH-1:0]    boid_x,
    input  logic [COORD_WIDTH-1:0]    boid_y,
    output logic                      fb_swap,
    output logic                      fb_we,
    output logic [ADDR_WIDTH-1:0]     fb_write_addr,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                dropped_frames
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SWAP  = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] DRAW  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam int PW = COORD_WIDTH + 1;  // one guard bit so bx+dx never wraps

    localparam logic [2:0]                S_LAST   = 3'(SPRITE_SIZE - 1);
    localparam logic [BOID_IDX_WIDTH-1:0] IDX_LAST = BOID_IDX_WIDTH'(NUM_BOIDS - 1);
    localparam logic [PW-1:0]             SW       = PW'(SCREEN_W);
    localparam logic [PW-1:0]             SH       = PW'(SCREEN_H);
    localparam logic [ADDR_WIDTH-1:0]     SW_A     = ADDR_WIDTH'(SCREEN_W);

    logic [2:0]                state;
    logic [BOID_IDX_WIDTH-1:0] index;
    logic [COORD_WIDTH-1:0]    bx, by;
    logic [2:0]                dx, dy;

    logic [PW-1:0]         px, py;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] pix_addr;

    always_comb begin
        px       = PW'(bx) + PW'(dx);
        py       = PW'(by) + PW'(dy);
        in_range = (px < SW) && (py < SH);
        // Only used when in range, where the product fits ADDR_WIDTH exactly.
        pix_addr = ADDR_WIDTH'(py) * SW_A + ADDR_WIDTH'(px);
    end

    // Status outputs are decodes of the state register, so reset clears them
    // immediately.
    assign fb_swap    = (state == SWAP);
    assign frame_done = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            index         <= '0;
            boid_addr     <= '0;
            bx            <= '0;
            by            <= '0;
            dx            <= '0;
            dy            <= '0;
            fb_we         <= 1'b0;
            fb_write_addr <= '0;
        end else begin
            fb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) state <= SWAP;
                end
                SWAP: begin
                    index     <= '0;
                    boid_addr <= '0;
                    state     <= FETCH;
                end
                FETCH: begin
                    // RAM samples boid_addr on this edge; data is valid in LATCH.
                    state <= LATCH;
                end
                LATCH: begin
                    bx    <= boid_x;
                    by    <= boid_y;
                    dx    <= '0;
                    dy    <= '0;
                    state <= DRAW;
                end
                DRAW: begin
                    // Write slot lands in the following cycle; clipped pixels
                    // simply leave fb_we low for that slot.
                    fb_we <= in_range;
                    if (in_range) fb_write_addr <= pix_addr;
                    if (dx == S_LAST) begin
                        dx <= '0;
                        if (dy == S_LAST) begin
                            dy <= '0;
                            if (index == IDX_LAST) begin
                                state <= DONE;
                            end else begin
                                index     <= index + 1'b1;
                                boid_addr <= index + 1'b1;
                                state     <= FETCH;
                            end
                        end else begin
                            dy <= dy + 1'b1;
                        end
                    end else begin
                        dx <= dx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Any tick that arrives outside IDLE (DONE included) is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropped_frames <= '0;
        end else if (frame_start && (state != IDLE) && (dropped_frames != 8'hFF)) begin
            dropped_frames <= dropped_frames + 8'd1;
        end
    end

endmodule
